bcd_key_entry: RTL and testbench

- Keypad entry stage that consumes the inverted-BCD outputs (d,c,b,a) of an sn74ls147 10-to-4 priority encoder plus a separate active-low "0" key line.
- Synchronises and debounces the key code and emits a one-cycle strobe per accepted keystroke.
- Shifts accepted digits into a packed multi-digit BCD entry register.
- Sits directly downstream of the sn74ls147 in keypad/front-panel models.

---
 rtl/bcd_key_entry_pkg.sv | 35 +++
 rtl/bcd_key_debounce.sv | 100 ++++++++++
 rtl/bcd_key_entry.sv | 82 ++++++++
 tb/tb_bcd_key_entry.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_key_entry_pkg.sv
// Shared types and helpers for the keypad entry stage fed by an sn74ls147 encoder.
package bcd_key_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } key_state_e;

    typedef struct packed {
        logic       pressed;
        logic [3:0] value;
    } key_sample_t;

    localparam logic [3:0] CODE_RELEASED = 4'b1111;
    localparam logic [4:0] SYNC_RELEASED = 5'b11111;

    // s = {key0_n, d, c, b, a}; encoder has priority over the separate 0 key,
    // and encoder codes above 9 are treated as no key.
    function automatic key_sample_t decode_key(input logic [4:0] s);
        key_sample_t r;
        r.pressed = 1'b0;
        r.value   = 4'd0;
        if (s[3:0] != CODE_RELEASED) begin
            r.value   = ~s[3:0];
            r.pressed = (r.value <= 4'd9);
            if (!r.pressed) r.value = 4'd0;
        end else if (!s[4]) begin
            r.pressed = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_key_debounce.sv
// Two-flop synchroniser, key decode and press/release debounce FSM.
// state    | meaning
// IDLE     | no key, waiting for a press
// PRESS    | candidate key seen, counting stable samples
// HELD     | key accepted, waiting for release
// RELEASE  | release seen, counting stable released samples
module bcd_key_debounce
    import bcd_key_entry_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       key0_n,
    output logic [3:0] digit,
    output logic       valid,
    output logic       key_down
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    logic [4:0]  sync1_q, sync2_q;
    key_state_e  state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  cand_q;
    logic [3:0]  digit_q;
    logic        valid_q;
    logic        key_down_q;
    key_sample_t smp;

    assign smp = decode_key(sync2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= SYNC_RELEASED;
            sync2_q    <= SYNC_RELEASED;
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            cand_q     <= 4'd0;
            digit_q    <= 4'd0;
            valid_q    <= 1'b0;
            key_down_q <= 1'b0;
        end else begin
            sync1_q <= {key0_n, d, c, b, a};
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (smp.pressed) begin
                        state_q <= ST_PRESS;
                        cand_q  <= smp.value;
                        cnt_q   <= 8'd1;
                    end
                end
                ST_PRESS: begin
                    if (!smp.pressed) begin
                        state_q <= ST_IDLE;
                    end else if (smp.value != cand_q) begin
                        cand_q <= smp.value;
                        cnt_q  <= 8'd1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_HELD;
                        digit_q    <= cand_q;
                        valid_q    <= 1'b1;
                        key_down_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_HELD: begin
                    // a different key while held is deliberately ignored (no rollover)
                    if (!smp.pressed) begin
                        state_q <= ST_RELEASE;
                        cnt_q   <= 8'd1;
                    end
                end
                ST_RELEASE: begin
                    if (smp.pressed) begin
                        state_q <= ST_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_IDLE;
                        key_down_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign digit    = digit_q;
    assign valid    = valid_q;
    assign key_down = key_down_q;

endmodule

// File: rtl/bcd_key_entry.sv
// Keypad entry stage: debounced sn74ls147 key codes shifted into a packed BCD entry register.
module bcd_key_entry
    import bcd_key_entry_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a,
    input  logic                  b,
    input  logic                  c,
    input  logic                  d,
    input  logic                  key0_n,
    input  logic                  clr_entry,
    output logic [3:0]            digit,
    output logic                  valid,
    output logic                  key_down,
    output logic [4*DIGITS-1:0]   entry,
    output logic [3:0]            count,
    output logic                  full,
    output logic                  overrun
);

    localparam logic [3:0] DIG_MAX = 4'(DIGITS);

    logic [4*DIGITS-1:0] entry_q, entry_d;
    logic [3:0]          count_q, count_d;
    logic                overrun_q, overrun_d;

    bcd_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .key0_n   (key0_n),
        .digit    (digit),
        .valid    (valid),
        .key_down (key_down)
    );

    // clear is applied first so a coincident accept lands in an empty register
    always_comb begin
        entry_d   = entry_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (clr_entry) begin
            entry_d   = '0;
            count_d   = 4'd0;
            overrun_d = 1'b0;
        end
        if (valid) begin
            if (count_d < DIG_MAX) begin
                entry_d      = entry_d << 4;
                entry_d[3:0] = digit;
                count_d      = count_d + 4'd1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q   <= '0;
            count_q   <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            entry_q   <= entry_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign entry   = entry_q;
    assign count   = count_q;
    assign full    = (count_q == DIG_MAX);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Randomised and directed bench for bcd_key_entry against a run-length reference model.
module tb_bcd_key_entry;

    localparam int DEB = 4;
    localparam int DIG = 4;
    localparam logic [4:0] REL = 5'b11111;

    logic        clk = 1'b0;
    logic        rst, clr_entry;
    logic [4:0]  keys;
    logic [3:0]  digit, count;
    logic        valid, key_down, full, overrun;
    logic [15:0] entry;

    int total = 0;
    int bad   = 0;
    int nvalid = 0;

    // reference model state
    logic [4:0] h1, h2;
    int  run_key, run_len;
    bit  m_kd, m_valid, m_ovr;
    int  m_digit;
    int  q[$];

    always #5 clk = ~clk;

    bcd_key_entry #(.DEBOUNCE(DEB), .DIGITS(DIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (keys[0]),
        .b         (keys[1]),
        .c         (keys[2]),
        .d         (keys[3]),
        .key0_n    (keys[4]),
        .clr_entry (clr_entry),
        .digit     (digit),
        .valid     (valid),
        .key_down  (key_down),
        .entry     (entry),
        .count     (count),
        .full      (full),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] key(input int n);
        logic [3:0] v;
        v = 4'(n);
        return (n == 0) ? 5'b01111 : {1'b1, ~v};
    endfunction

    // key number 0..9, or 16 for no key / illegal code
    function automatic int key_of(input logic [4:0] s);
        int v;
        if (s[3:0] != 4'hF) begin
            v = 15 - int'(s[3:0]);
            return (v <= 9) ? v : 16;
        end
        return s[4] ? 16 : 0;
    endfunction

    function automatic logic [15:0] model_entry();
        logic [15:0] e;
        e = '0;
        for (int i = 0; i < q.size(); i++) e[4*i +: 4] = 4'(q[q.size()-1-i]);
        return e;
    endfunction

    task automatic model_step(input logic [4:0] k, input logic r, input logic c);
        int s;
        if (r) begin
            h1 = REL; h2 = REL;
            run_key = 16; run_len = 0;
            m_kd = 0; m_valid = 0; m_digit = 0; m_ovr = 0;
            q.delete();
            return;
        end
        if (c) begin
            q.delete();
            m_ovr = 0;
        end
        if (m_valid) begin
            if (q.size() < DIG) q.push_back(m_digit);
            else m_ovr = 1;
        end
        s  = key_of(h2);
        h2 = h1;
        h1 = k;
        if (run_len > 0 && s == run_key) run_len++;
        else begin
            run_key = s;
            run_len = 1;
        end
        m_valid = 0;
        if (!m_kd && s != 16 && run_len == DEB) begin
            m_kd = 1; m_valid = 1; m_digit = s;
        end else if (m_kd && s == 16 && run_len == DEB) begin
            m_kd = 0;
        end
    endtask

    task automatic check_all();
        chk("digit",    32'(digit),    32'(m_digit));
        chk("valid",    32'(valid),    32'(m_valid));
        chk("key_down", 32'(key_down), 32'(m_kd));
        chk("entry",    32'(entry),    32'(model_entry()));
        chk("count",    32'(count),    32'(q.size()));
        chk("full",     32'(full),     32'(q.size() == DIG));
        chk("overrun",  32'(overrun),  32'(m_ovr));
    endtask

    task automatic step(input logic [4:0] k, input logic r, input logic c, input int n);
        repeat (n) begin
            keys = k; rst = r; clr_entry = c;
            @(posedge clk);
            model_step(k, r, c);
            #1;
            if (valid) nvalid++;
            check_all();
        end
    endtask

    task automatic press(input int n);
        step(key(n), 0, 0, 8);
        step(REL, 0, 0, 8);
    endtask

    initial begin
        int snap;
        logic [4:0] k;
        int dur;
        keys = REL; rst = 1'b1; clr_entry = 1'b0;
        step(REL, 1, 0, 3);

        // key 7: strobe appears on the sixth edge after the code is applied
        step(key(7), 0, 0, 5);
        chk("k7_pre", 32'(valid), 0);
        step(key(7), 0, 0, 1);
        chk("k7_lat", 32'(valid), 1);
        step(key(7), 0, 0, 14);
        chk("k7_entry", 32'(entry), 32'h0007);
        chk("k7_down", 32'(key_down), 1);
        step(REL, 0, 0, 10);
        chk("k7_up", 32'(key_down), 0);

        snap = nvalid;
        for (int i = 0; i < 5; i++) begin
            step(key(3), 0, 0, 2);
            step(REL, 0, 0, 2);
        end
        step(key(3), 0, 0, 10);
        step(REL, 0, 0, 10);
        chk("bounce_strobes", 32'(nvalid - snap), 1);
        chk("bounce_digit", 32'(digit), 3);

        press(0);
        chk("key0_digit", 32'(digit), 0);
        step(5'b01110, 0, 0, 8);
        step(REL, 0, 0, 8);
        chk("key0_prio", 32'(digit), 1);

        step(REL, 0, 1, 1);
        press(9); press(8); press(7); press(6);
        chk("fill_entry", 32'(entry), 32'h9876);
        chk("fill_full", 32'(full), 1);
        press(5);
        chk("ovr_entry", 32'(entry), 32'h9876);
        chk("ovr_flag", 32'(overrun), 1);
        step(REL, 0, 1, 1);
        chk("clr_entry", 32'(entry), 0);
        chk("clr_ovr", 32'(overrun), 0);

        press(5);
        step(key(4), 0, 0, 6);
        step(key(4), 0, 1, 1);
        chk("clr_acc_entry", 32'(entry), 32'h0004);
        chk("clr_acc_count", 32'(count), 1);
        step(REL, 0, 0, 8);

        snap = nvalid;
        step(key(7), 0, 0, 8);
        step(key(2), 0, 0, 8);
        step(REL, 0, 0, 8);
        chk("rollover_strobes", 32'(nvalid - snap), 1);

        step(key(5), 0, 0, 3);
        step(key(5), 1, 0, 1);
        chk("rst_entry", 32'(entry), 0);
        chk("rst_down", 32'(key_down), 0);
        step(key(5), 0, 0, 5);
        chk("rst_pre", 32'(valid), 0);
        step(key(5), 0, 0, 1);
        chk("rst_lat", 32'(valid), 1);
        chk("rst_digit", 32'(digit), 5);
        step(REL, 0, 0, 8);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    k = REL;
                2:       k = key(0);
                3:       k = {1'($urandom_range(0, 1)), ~4'($urandom_range(10, 15))};
                default: k = key($urandom_range(1, 9));
            endcase
            dur = $urandom_range(1, 7);
            step(k, 0, 0, dur);
            if ($urandom_range(0, 9) == 0) step(k, 0, 1, 1);
            if ($urandom_range(0, 49) == 0) step(k, 1, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
